// File: rtl/fifo_read_drain.sv
// fifo_read_drain: rclk-domain FIFO consumer that issues credit-gated reads into a
// 2-entry skid buffer and streams words out on valid/ready, with read/error counters.
module fifo_read_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  empty,
  input  logic                  read_error,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [7:0]            err_count,
  output logic                  busy
);
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic [7:0]            err_count_q;
  logic                  pop;
  // occupancy after this cycle's capture and pop; a read is allowed only if it will fit
  assign pop      = m_valid & m_ready;
  assign occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign r_en     = enable & ~empty & ~rrst & (occ_d < 2'd2);
  assign m_valid  = occ_q != 2'd0;
  assign m_data   = buf_q[rd_ptr_q];
  assign busy     = inflight_q | m_valid;
  assign rd_count = rd_count_q;
  assign err_count = err_count_q;
  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      inflight_q  <= r_en;
      occ_q       <= occ_d;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      rd_count_q  <= rd_count_q + CNT_WIDTH'(r_en);
      err_count_q <= err_count_q + 8'(read_error & ~&err_count_q);
    end
  end
endmodule

// File: tb/tb_fifo_read_drain.sv
// tb_fifo_read_drain: queue-based FIFO environment and buffer model checked every cycle,
// plus directed scenario checks on the delivered word stream.
module tb_fifo_read_drain;
  logic       clk = 1'b0;
  logic       rrst, enable, empty, read_error, m_ready;
  logic [7:0] fifo_data;
  logic       r_en, m_valid, busy;
  logic [7:0] m_data, err_count;
  logic [15:0] rd_count;
  int total = 0, bad = 0;
  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] outq[$];
  int fl, ec;
  logic [15:0] rc;
  logic [7:0] fd;

  fifo_read_drain dut (
    .rclk(clk), .rrst(rrst), .enable(enable), .empty(empty), .read_error(read_error),
    .fifo_data(fifo_data), .r_en(r_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .rd_count(rd_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic ep, er, dren;
    empty = (fq.size() == 0);
    fifo_data = fd;
    #3;
    ep = (mq.size() != 0) && m_ready;
    er = enable && !empty && !rrst && (mq.size() + fl - int'(ep) < 2);
    dren = r_en;
    chk("r_en", r_en, er);
    chk("r_en_while_empty", r_en & empty, 0);
    chk("m_valid", m_valid, mq.size() != 0);
    if (mq.size() != 0) chk("m_data", m_data, mq[0]);
    chk("busy", busy, fl != 0 || mq.size() != 0);
    chk("rd_count", rd_count, rc);
    chk("err_count", err_count, ec);
    if (m_valid && m_ready) outq.push_back(m_data);
    @(posedge clk);
    if (rrst) begin
      mq.delete(); fl = 0; rc = 0; ec = 0;
    end else begin
      if (ep) void'(mq.pop_front());
      if (fl != 0) mq.push_back(fd);
      fl = int'(er);
      rc = rc + 16'(er);
      if (read_error && ec < 255) ec++;
    end
    if (dren && fq.size() != 0) fd = fq.pop_front(); else fd = 8'($urandom);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic rst1();
    fq.delete();
    rrst = 1'b1;
    cyc();
    rrst = 1'b0;
    outq.delete();
  endtask

  initial begin
    rrst = 1'b1; enable = 1'b0; empty = 1'b1; read_error = 1'b0; m_ready = 1'b0;
    fifo_data = '0; fd = '0; fl = 0; ec = 0; rc = '0;
    @(posedge clk); #1;
    rst1();
    chk("reset_m_data", m_data, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_count", rd_count, 0);
    // single word
    fq.push_back(8'hA5); enable = 1'b1; m_ready = 1'b1;
    run(6);
    chk("single_n", outq.size(), 1);
    if (outq.size() > 0) chk("single_word", outq[0], 8'hA5);
    chk("single_rd_count", rd_count, 1);
    chk("single_busy", busy, 0);
    // burst
    rst1();
    for (int i = 0; i < 16; i++) fq.push_back(8'(i));
    run(22);
    chk("burst_n", outq.size(), 16);
    for (int i = 0; i < outq.size(); i++) chk("burst_word", outq[i], i);
    chk("burst_rd_count", rd_count, 16);
    chk("burst_err_count", err_count, 0);
    // backpressure
    rst1();
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h30 + i));
    m_ready = 1'b0;
    run(8);
    chk("bp_rd_count", rd_count, 2);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_m_data", m_data, 8'h30);
    m_ready = 1'b1;
    run(14);
    chk("bp_n", outq.size(), 8);
    for (int i = 0; i < outq.size(); i++) chk("bp_word", outq[i], 8'h30 + i);
    chk("bp_rd_count_end", rd_count, 8);
    // enable gating
    rst1();
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h50 + i));
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    run(6);
    chk("gate_rd_count", rd_count, 1);
    chk("gate_n", outq.size(), 1);
    enable = 1'b1;
    run(8);
    chk("gate_n_end", outq.size(), 4);
    for (int i = 0; i < outq.size(); i++) chk("gate_word", outq[i], 8'h50 + i);
    // reset mid-burst
    rst1();
    for (int i = 0; i < 10; i++) fq.push_back(8'(8'h70 + i));
    run(4);
    rrst = 1'b1;
    cyc();
    rrst = 1'b0;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    chk("mid_rst_err_count", err_count, 0);
    outq.delete();
    run(14);
    chk("mid_rst_n", outq.size(), 6);
    for (int i = 0; i < outq.size(); i++) chk("mid_rst_word", outq[i], 8'h74 + i);
    chk("mid_rst_rd_count_end", rd_count, 6);
    // randomized traffic
    rst1();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      read_error = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) fq.push_back(8'($urandom));
      cyc();
    end
    enable = 1'b1; m_ready = 1'b1; read_error = 1'b0;
    for (int c = 0; c < 200 && (fq.size() != 0 || mq.size() != 0 || fl != 0); c++) cyc();
    chk("rand_drained", busy, 0);
    chk("rand_fifo_empty", fq.size(), 0);
    // error saturation
    rst1();
    read_error = 1'b1;
    run(300);
    chk("err_sat", err_count, 255);
    run(5);
    chk("err_hold", err_count, 255);
    read_error = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_read_drain.md
Name: fifo_read_drain

Overview:
- Read-side consumer for asynchronous_fifo, running entirely in the rclk domain.
- Issues r_en only when the FIFO reports non-empty and local buffer credit exists.
- Absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer and presents words downstream on a valid/ready stream.
- Counts words read and FIFO read_error events for the bench and for software status.

Parameters:
DATA_WIDTH, 8, width of FIFO data_out and of m_data
CNT_WIDTH, 16, width of rd_count (wraps)

Ports:
rclk  input  1  read-domain clock, shared with asynchronous_fifo rclk
rrst  input  1  synchronous active-high reset
enable  input  1  1 = allow new FIFO reads; 0 = stop issuing r_en, keep draining the buffer
empty  input  1  FIFO empty flag (rclk domain)
read_error  input  1  FIFO read_error flag
fifo_data  input  DATA_WIDTH  FIFO data_out
r_en  output  1  FIFO read enable (combinational)
m_data  output  DATA_WIDTH  downstream data, head of skid buffer
m_valid  output  1  downstream valid
m_ready  input  1  downstream ready
rd_count  output  CNT_WIDTH  number of r_en pulses issued, wraps modulo 2^CNT_WIDTH
err_count  output  8  read_error cycles seen, saturates at 255
busy  output  1  read in flight or buffer non-empty

Behaviour:
- Interface is decided: one clock (rclk); reset rrst is synchronous and active-high.
- Reset: on a rclk edge with rrst=1, the following are cleared:
  - inflight=0, occ=0, buffer pointers 0, rd_count=0, err_count=0.
  - Outputs then read r_en=0, m_valid=0, busy=0, m_data=0.
  - Any word in flight is discarded.
  - r_en is forced 0 while rrst=1.
- FIFO read contract: r_en=1 with empty=0 in cycle T puts the word on fifo_data in cycle T+1. It is captured at the end of T+1.
- State:
  - inflight (1 bit): registered r_en.
  - occ (0..2): buffer occupancy.
  - Buffer: 2 entries with wrap-around rd/wr pointers.
- pop = m_valid & m_ready.
- r_en = enable & ~empty & ~rrst & (occ + inflight - pop < 2).
  - Controller never reads an empty FIFO.
  - read_error from the controller's own reads is impossible; any read_error seen is counted anyway.
- Capture: if inflight=1, fifo_data is written at wr_ptr and wr_ptr advances.
- Pop: head advances.
- occ_next = occ + inflight - pop.
  - Simultaneous capture and pop leaves occ unchanged.
  - occ never exceeds 2 by construction.
- m_valid = (occ != 0); m_data = buffer[rd_ptr].
- m_data is held stable while m_valid=1 and m_ready=0.
- Latency: r_en in cycle T, m_valid first high in cycle T+2 (buffer empty beforehand).
- Throughput: with empty=0, enable=1 and m_ready=1 continuously, one word per cycle in steady state.
- Backpressure: with m_ready=0, at most 2 r_en pulses are issued, then r_en stays 0 until a pop.
- enable falling: no new r_en from that cycle on. An already in-flight word is still captured, and buffered words still drain.
- empty rising mid-burst: r_en drops in the same cycle, and the in-flight word is still captured.
- rd_count: +1 on every cycle with r_en=1, wraps to 0 from 2^CNT_WIDTH-1.
- err_count: +1 on every cycle with read_error=1, holds at 255.
- busy = inflight | (occ != 0).
- Reset mid-burst clears the buffer and inflight. The word returned by the FIFO in the following cycle is ignored, because inflight is already 0.

Test Plan:
- Single word: reset, FIFO holds 0xA5, enable=1, m_ready=1. Required:
  - exactly one r_en pulse;
  - m_valid high for one cycle, 2 cycles after r_en, with m_data=0xA5;
  - rd_count=1, then busy=0.
- Burst: write 0x00..0x0F, enable=1, m_ready=1. Required:
  - 16 words out in order, back-to-back after the first;
  - rd_count=16, err_count=0;
  - r_en never high while empty=1.
- Backpressure: FIFO holds 8 words, m_ready=0. Required:
  - exactly 2 r_en pulses, m_valid=1, m_data stable at word 0.
  - Then raise m_ready: all 8 words in order, rd_count=8.
- Enable gating: drop enable one cycle after the first r_en of a 4-word burst. Required:
  - the in-flight word(s) are delivered and no further r_en occurs;
  - re-enabling delivers the rest in order.
- Reset mid-burst: assert rrst for 1 cycle during a streaming burst. Required:
  - next cycle m_valid=0, occ=0, rd_count=0, err_count=0;
  - after release, reading resumes with the next FIFO word and no stale word appears.
- Error counting: drive read_error=1 for 300 cycles. Required: err_count=255, held there.
